// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - single-issue function-code sequencer for the ALU/shifter/multiplier/HiLo datapath
//
// Accepts one request at a time and drives the datapath function select.
// Runs the MULTU sequence: start pulse, countdown, then a HiLo write.
// Returns a tagged response on a second valid/ready handshake.
//
// Optional build macro: ALU_SEQ_MUL_OVERLAP_EN
//   When defined, MULTU responds at once and the multiply runs in the background.
//   While the multiply is running, MULTU, MFHI and MFLO are held off.
//   When undefined, operation is strictly serial.
//
// Ports:
//   clk, reset              clock, asynchronous active-low reset
//   req_valid/req_ready     request handshake; req_funct, req_tag carry the request
//   alu_signal              datapath function select, valid while rsp_valid
//   mul_start, mul_busy     multiplier launch pulse and in-progress flag
//   hilo_we                 one-cycle HiLo write strobe
//   rsp_valid/rsp_ready     response handshake; rsp_tag, rsp_has_data, rsp_err describe it
module alu_op_sequencer #(
  parameter int MUL_CYCLES = 32,
  parameter int TAG_W      = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [5:0]       req_funct,
  input  logic [TAG_W-1:0] req_tag,
  output logic [5:0]       alu_signal,
  output logic             mul_start,
  output logic             mul_busy,
  output logic             hilo_we,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_has_data,
  output logic             rsp_err
);

`ifdef ALU_SEQ_MUL_OVERLAP_EN
  localparam bit OverlapEn = 1'b1;
`else
  localparam bit OverlapEn = 1'b0;
`endif

  localparam logic [5:0] F_AND   = 6'd36;
  localparam logic [5:0] F_OR    = 6'd37;
  localparam logic [5:0] F_ADD   = 6'd32;
  localparam logic [5:0] F_SUB   = 6'd34;
  localparam logic [5:0] F_SLT   = 6'd42;
  localparam logic [5:0] F_SRL   = 6'd2;
  localparam logic [5:0] F_MULTU = 6'd25;
  localparam logic [5:0] F_MFHI  = 6'd16;
  localparam logic [5:0] F_MFLO  = 6'd18;
  localparam logic [7:0] CntLoad = 8'(MUL_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_RSP} state_e;

  state_e           state_q, state_d;
  logic             alive_q;
  logic [7:0]       cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [5:0]       sig_q, sig_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             has_data_q, has_data_d;
  logic             err_q, err_d;
  logic             legal, is_mul, is_hilo_rd, ready_c;

  always_comb begin
    legal = 1'b0;
    case (req_funct)
      F_AND, F_OR, F_ADD, F_SUB, F_SLT, F_SRL, F_MULTU, F_MFHI, F_MFLO: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  assign is_mul     = (req_funct == F_MULTU);
  assign is_hilo_rd = (req_funct == F_MFHI) || (req_funct == F_MFLO);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    sig_d      = sig_q;
    tag_d      = tag_q;
    has_data_d = has_data_q;
    err_d      = err_q;
    ready_c    = 1'b0;

    // The multiply countdown runs independently of the foreground state so the
    // same logic serves both the serial and the overlapped build.
    if (busy_q) begin
      if (cnt_q == 8'd0) busy_d = 1'b0;
      else               cnt_d  = cnt_q - 8'd1;
    end

    case (state_q)
      S_IDLE: begin
        // alive_q keeps req_ready low until the first edge after reset release.
        ready_c = alive_q && !(OverlapEn && busy_q && (is_mul || is_hilo_rd));
        if (req_valid && ready_c) begin
          sig_d      = legal ? req_funct : 6'd0;
          tag_d      = req_tag;
          has_data_d = legal && !is_mul;
          err_d      = !legal;
          state_d    = S_RSP;
          if (is_mul) begin
            busy_d = 1'b1;
            cnt_d  = CntLoad;
            if (!OverlapEn) state_d = S_MUL;
          end
        end
      end
      S_MUL: begin
        if (busy_q && (cnt_q == 8'd0)) state_d = S_RSP;
      end
      S_RSP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      alive_q    <= 1'b0;
      cnt_q      <= 8'd0;
      busy_q     <= 1'b0;
      sig_q      <= 6'd0;
      tag_q      <= '0;
      has_data_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      alive_q    <= 1'b1;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      sig_q      <= sig_d;
      tag_q      <= tag_d;
      has_data_q <= has_data_d;
      err_q      <= err_d;
    end
  end

  assign req_ready    = ready_c;
  assign rsp_valid    = (state_q == S_RSP);
  assign alu_signal   = rsp_valid ? sig_q : 6'd0;
  assign rsp_tag      = rsp_valid ? tag_q : '0;
  assign rsp_has_data = rsp_valid && has_data_q;
  assign rsp_err      = rsp_valid && err_q;
  assign mul_busy     = busy_q;
  assign mul_start    = busy_q && (cnt_q == CntLoad);
  assign hilo_we      = busy_q && (cnt_q == 8'd0);

endmodule
